vend_sequencer: RTL and testbench

Cycle-accurate controller for the vending datapath. It accepts coin strobes, accumulates credit in nickel units, and arbitrates simultaneous coins and simultaneous product selections. It then sequences the dispense output and a counted train of change pulses. All timing comes from clock-cycle counters, so the block is fully synthesizable and contains no delay statements. It sits between the coin/button input conditioning and the product/change dispenser drivers.

---
 rtl/vend_sequencer_if.sv | 24 ++
 rtl/vend_sequencer.sv | 148 ++++++++++++++
 tb/tb_vend_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_sequencer_if.sv
// Handshake bundle between the vending sequencer and its input conditioning / dispenser drivers.
interface vend_sequencer_if;
  logic       ni;
  logic       di;
  logic       qu;
  logic       soda;
  logic       diet;
  logic       giveSoda;
  logic       giveDiet;
  logic       change;
  logic       coin_reject;
  logic       busy;
  logic [3:0] credit;

  modport master (
    output ni, di, qu, soda, diet,
    input  giveSoda, giveDiet, change, coin_reject, busy, credit
  );

  modport slave (
    input  ni, di, qu, soda, diet,
    output giveSoda, giveDiet, change, coin_reject, busy, credit
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending controller: coin crediting with arbitration, product vend timing and a counted change-pulse train.
//
// state  | meaning
// IDLE   | accepting coins, waiting for a paid selection
// VEND   | give output held for VEND_CYC cycles
// CHG_HI | change pulse high for PULSE_CYC cycles
// CHG_LO | gap after a change pulse for GAP_CYC cycles
module vend_sequencer #(
  parameter int PRICE     = 9,
  parameter int VEND_CYC  = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 2
) (
  input logic             CLK,
  input logic             rst,
  vend_sequencer_if.slave bus
);

  localparam int TMAX_A = (VEND_CYC > PULSE_CYC) ? VEND_CYC : PULSE_CYC;
  localparam int TMAX   = (TMAX_A > GAP_CYC) ? TMAX_A : GAP_CYC;
  localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [3:0]    PRICE4  = 4'(PRICE);
  localparam logic [TW-1:0] T_VEND  = TW'(VEND_CYC - 1);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, VEND, CHG_HI, CHG_LO} state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0]    credit, credit_d;
  logic [3:0]    refund, refund_d;
  logic [3:0]    coin_val;
  logic          sel_soda, sel_soda_d;
  logic          prev_ni, prev_di, prev_qu;
  logic          edge_ni, edge_di, edge_qu;
  logic          any_edge, lost_edge, reject_d;
  logic          give_soda_d, give_diet_d, change_d, busy_d;

  assign edge_ni   = bus.ni & ~prev_ni;
  assign edge_di   = bus.di & ~prev_di;
  assign edge_qu   = bus.qu & ~prev_qu;
  assign any_edge  = edge_ni | edge_di | edge_qu;
  assign lost_edge = (edge_qu & (edge_di | edge_ni)) | (edge_di & edge_ni);
  assign coin_val  = edge_qu ? 4'd5 : edge_di ? 4'd2 : edge_ni ? 4'd1 : 4'd0;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= '0;
      credit          <= 4'd0;
      refund          <= 4'd0;
      sel_soda        <= 1'b0;
      prev_ni         <= bus.ni;
      prev_di         <= bus.di;
      prev_qu         <= bus.qu;
      bus.giveSoda    <= 1'b0;
      bus.giveDiet    <= 1'b0;
      bus.change      <= 1'b0;
      bus.coin_reject <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_d;
      timer           <= timer_d;
      credit          <= credit_d;
      refund          <= refund_d;
      sel_soda        <= sel_soda_d;
      prev_ni         <= bus.ni;
      prev_di         <= bus.di;
      prev_qu         <= bus.qu;
      bus.giveSoda    <= give_soda_d;
      bus.giveDiet    <= give_diet_d;
      bus.change      <= change_d;
      bus.coin_reject <= reject_d;
      bus.busy        <= busy_d;
    end
  end

  // Outside IDLE every coin edge is refused; inside IDLE a paid selection outranks any coin.
  always_comb begin
    state_d    = state;
    timer_d    = timer;
    credit_d   = credit;
    refund_d   = refund;
    sel_soda_d = sel_soda;
    reject_d   = any_edge;
    unique case (state)
      IDLE: begin
        if (credit >= PRICE4 && (bus.soda || bus.diet)) begin
          state_d    = VEND;
          timer_d    = T_VEND;
          refund_d   = credit - PRICE4;
          credit_d   = 4'd0;
          sel_soda_d = bus.soda;
        end else if (credit < PRICE4) begin
          credit_d = credit + coin_val;
          reject_d = lost_edge;
        end
      end
      VEND: begin
        if (timer == '0) begin
          if (refund != 4'd0) begin
            state_d = CHG_HI;
            timer_d = T_PULSE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      CHG_HI: begin
        if (timer == '0) begin
          state_d  = CHG_LO;
          timer_d  = T_GAP;
          refund_d = refund - 4'd1;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      CHG_LO: begin
        if (timer == '0) begin
          if (refund != 4'd0) begin
            state_d = CHG_HI;
            timer_d = T_PULSE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered outputs line up with the state they describe.
  always_comb begin
    give_soda_d = (state_d == VEND) && sel_soda_d;
    give_diet_d = (state_d == VEND) && !sel_soda_d;
    change_d    = (state_d == CHG_HI);
    busy_d      = (state_d != IDLE);
  end

  assign bus.credit = credit;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: coin crediting, arbitration, vend/change timing and reset abort.
module tb_vend_sequencer;

  localparam int PRICE     = 9;
  localparam int VEND_CYC  = 4;
  localparam int PULSE_CYC = 2;
  localparam int GAP_CYC   = 2;

  logic CLK;
  logic rst;
  int   checks;
  int   errors;

  // {credit[3:0], coin_reject, giveSoda, giveDiet, change, busy} per observed cycle
  logic [8:0] trace [0:31];

  vend_sequencer_if bus ();

  vend_sequencer #(
    .PRICE     (PRICE),
    .VEND_CYC  (VEND_CYC),
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected observation k cycles after a paid selection edge, n change pulses, credit cleared to 0.
  function automatic logic [8:0] exp_vec(input int k, input bit soda_sel, input int n);
    int j;
    int per;
    per = PULSE_CYC + GAP_CYC;
    if (k <= VEND_CYC) return {4'd0, 1'b0, soda_sel, !soda_sel, 1'b0, 1'b1};
    j = k - VEND_CYC - 1;
    if (j < n * per) return {4'd0, 1'b0, 1'b0, 1'b0, (j % per) < PULSE_CYC, 1'b1};
    return 9'd0;
  endfunction

  function automatic logic [8:0] snap();
    return {bus.credit, bus.coin_reject, bus.giveSoda, bus.giveDiet, bus.change, bus.busy};
  endfunction

  task automatic record(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      trace[k] = snap();
    end
  endtask

  // kind: 0 nickel, 1 dime, 2 quarter; one rising edge then one low cycle
  task automatic coin(input int kind);
    case (kind)
      0: bus.ni = 1'b1;
      1: bus.di = 1'b1;
      default: bus.qu = 1'b1;
    endcase
    @(negedge CLK);
    bus.ni = 1'b0;
    bus.di = 1'b0;
    bus.qu = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (snap() !== 9'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", snap(), 9'd0);
    end
    rst = 1'b0;
    @(negedge CLK);
    checks++;
    if (snap() !== 9'd0) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", snap(), 9'd0);
    end
  endtask

  task automatic test_one_change();
    coin(2);
    checks++;
    if (bus.credit !== 4'd5) begin
      errors++;
      $display("FAIL one_change_credit1: got %0d expected 5", bus.credit);
    end
    coin(2);
    checks++;
    if (bus.credit !== 4'd10) begin
      errors++;
      $display("FAIL one_change_credit2: got %0d expected 10", bus.credit);
    end
    bus.soda = 1'b1;
    record(10);
    bus.soda = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k, 1'b1, 1)) begin
        errors++;
        $display("FAIL one_change_cycle%0d: got %b expected %b", k, trace[k], exp_vec(k, 1'b1, 1));
      end
    end
  endtask

  task automatic test_four_change();
    logic [3:0] want [0:3];
    want[0] = 4'd1; want[1] = 4'd3; want[2] = 4'd8; want[3] = 4'd13;
    for (int i = 0; i < 4; i++) begin
      coin(i == 0 ? 0 : i == 1 ? 1 : 2);
      checks++;
      if (bus.credit !== want[i]) begin
        errors++;
        $display("FAIL four_change_credit%0d: got %0d expected %0d", i, bus.credit, want[i]);
      end
    end
    bus.diet = 1'b1;
    record(22);
    bus.diet = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k, 1'b0, 4)) begin
        errors++;
        $display("FAIL four_change_cycle%0d: got %b expected %b", k, trace[k], exp_vec(k, 1'b0, 4));
      end
    end
  endtask

  task automatic test_exact_price();
    coin(2);
    coin(1);
    coin(1);
    checks++;
    if (bus.credit !== 4'd9) begin
      errors++;
      $display("FAIL exact_price_credit: got %0d expected 9", bus.credit);
    end
    bus.soda = 1'b1;
    record(8);
    bus.soda = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k, 1'b1, 0)) begin
        errors++;
        $display("FAIL exact_price_cycle%0d: got %b expected %b", k, trace[k], exp_vec(k, 1'b1, 0));
      end
    end
  endtask

  task automatic test_arbitration();
    bus.ni = 1'b1;
    bus.di = 1'b1;
    bus.qu = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.credit, bus.coin_reject} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL arb_triple: got credit %0d reject %b expected credit 5 reject 1", bus.credit, bus.coin_reject);
    end
    bus.ni = 1'b0;
    bus.di = 1'b0;
    bus.qu = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.credit, bus.coin_reject} !== {4'd5, 1'b0}) begin
      errors++;
      $display("FAIL arb_after: got credit %0d reject %b expected credit 5 reject 0", bus.credit, bus.coin_reject);
    end
    bus.di = 1'b1;
    bus.ni = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.credit, bus.coin_reject} !== {4'd7, 1'b1}) begin
      errors++;
      $display("FAIL arb_dime_nickel: got credit %0d reject %b expected credit 7 reject 1", bus.credit, bus.coin_reject);
    end
    bus.di = 1'b0;
    bus.ni = 1'b0;
    @(negedge CLK);
    coin(2);
    bus.soda = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.giveSoda, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL arb_vend_start: got give %b busy %b expected 1 1", bus.giveSoda, bus.busy);
    end
    bus.soda = 1'b0;
    bus.qu = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.credit, bus.coin_reject} !== {4'd0, 1'b1}) begin
      errors++;
      $display("FAIL arb_coin_in_vend: got credit %0d reject %b expected credit 0 reject 1", bus.credit, bus.coin_reject);
    end
    bus.qu = 1'b0;
    repeat (24) @(negedge CLK);
    checks++;
    if ({bus.credit, bus.busy} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL arb_return_idle: got credit %0d busy %b expected credit 0 busy 0", bus.credit, bus.busy);
    end
  endtask

  task automatic test_dual_select();
    coin(2);
    coin(2);
    bus.soda = 1'b1;
    bus.diet = 1'b1;
    record(14);
    bus.soda = 1'b0;
    bus.diet = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k, 1'b1, 1)) begin
        errors++;
        $display("FAIL dual_select_cycle%0d: got %b expected %b", k, trace[k], exp_vec(k, 1'b1, 1));
      end
    end
  endtask

  task automatic test_below_price();
    coin(2);
    coin(0);
    coin(0);
    coin(0);
    checks++;
    if (bus.credit !== 4'd8) begin
      errors++;
      $display("FAIL below_price_credit: got %0d expected 8", bus.credit);
    end
    bus.soda = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.credit, bus.giveSoda, bus.busy} !== {4'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL below_price_ignored: got credit %0d give %b busy %b expected 8 0 0",
               bus.credit, bus.giveSoda, bus.busy);
    end
    bus.soda = 1'b0;
    coin(1);
    checks++;
    if (bus.credit !== 4'd10) begin
      errors++;
      $display("FAIL below_price_topup: got %0d expected 10", bus.credit);
    end
    bus.ni = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.credit, bus.coin_reject} !== {4'd10, 1'b1}) begin
      errors++;
      $display("FAIL paid_coin_reject: got credit %0d reject %b expected credit 10 reject 1", bus.credit, bus.coin_reject);
    end
    bus.ni = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_abort();
    int seen;
    rst = 1'b1;
    bus.qu = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({bus.credit, bus.coin_reject} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL held_qu_reset: got credit %0d reject %b expected credit 0 reject 0", bus.credit, bus.coin_reject);
    end
    bus.qu = 1'b0;
    @(negedge CLK);
    coin(2);
    coin(0);
    coin(2);
    checks++;
    if (bus.credit !== 4'd11) begin
      errors++;
      $display("FAIL abort_credit: got %0d expected 11", bus.credit);
    end
    bus.soda = 1'b1;
    record(9);
    bus.soda = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (trace[k] !== exp_vec(k, 1'b1, 2)) begin
        errors++;
        $display("FAIL abort_cycle%0d: got %b expected %b", k, trace[k], exp_vec(k, 1'b1, 2));
      end
    end
    rst = 1'b1;
    bus.qu = 1'b1;
    @(negedge CLK);
    checks++;
    if (snap() !== 9'd0) begin
      errors++;
      $display("FAIL abort_reset: got %b expected %b", snap(), 9'd0);
    end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (snap() !== 9'd0) seen++;
    end
    bus.qu = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.ni    = 1'b0;
    bus.di    = 1'b0;
    bus.qu    = 1'b0;
    bus.soda  = 1'b0;
    bus.diet  = 1'b0;
    @(negedge CLK);
    test_reset();
    test_one_change();
    test_four_change();
    test_exact_price();
    test_arbitration();
    test_dual_select();
    test_below_price();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
